// File: rtl/score_pio_arbiter.sv
// Two-requester round-robin arbiter that turns accepted score updates into
// single-cycle write strobes on the ScoreX/ScoreY/ScoreVal PIO slaves.
module score_pio_arbiter #(
    parameter int DATA_W  = 16,
    parameter int MIN_GAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req0_sel,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req1_sel,
    input  logic [DATA_W-1:0] req1_data,
    output logic [2:0]        pio_chipselect,
    output logic [1:0]        pio_address,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    output logic              busy,
    output logic              err_sel
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam bit         HAS_GAP  = (MIN_GAP > 0);
    localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(MIN_GAP - 1) : 4'd0;

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] cs;
        case (sel)
            2'd0:    cs = 3'b001;
            2'd1:    cs = 3'b010;
            2'd2:    cs = 3'b100;
            default: cs = 3'b000;
        endcase
        return cs;
    endfunction

    logic [1:0]        state_r;
    logic [3:0]        gap_cnt_r;
    logic              last_grant_r;
    logic [2:0]        pio_cs_r;
    logic              pio_write_n_r;
    logic [31:0]       pio_writedata_r;
    logic              err_sel_r;

    logic [1:0]        grant_s;
    logic              xfer_s;
    logic [1:0]        xfer_sel_s;
    logic [DATA_W-1:0] xfer_data_s;

    // Grant depends only on state, valids and the round-robin pointer, never on sel/data.
    always_comb begin
        grant_s = 2'b00;
        if (reset || (state_r != ST_IDLE)) begin
            grant_s = 2'b00;
        end else begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end
    end

    // Payload mux for whichever requester holds the grant.
    always_comb begin
        xfer_s      = |grant_s;
        xfer_sel_s  = 2'd0;
        xfer_data_s = '0;
        if (grant_s[1]) begin
            xfer_sel_s  = req1_sel;
            xfer_data_s = req1_data;
        end else begin
            xfer_sel_s  = req0_sel;
            xfer_data_s = req0_data;
        end
    end

    // Sequencer; the PIO output registers double as the latched sel/data and clear after WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            gap_cnt_r       <= 4'd0;
            last_grant_r    <= 1'b1;
            pio_cs_r        <= 3'b000;
            pio_write_n_r   <= 1'b1;
            pio_writedata_r <= 32'd0;
            err_sel_r       <= 1'b0;
        end else begin
            pio_cs_r        <= 3'b000;
            pio_write_n_r   <= 1'b1;
            pio_writedata_r <= 32'd0;
            err_sel_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        last_grant_r <= grant_s[1];
                        if (xfer_sel_s == 2'd3) begin
                            err_sel_r <= 1'b1;
                        end else begin
                            pio_cs_r        <= sel_onehot(xfer_sel_s);
                            pio_write_n_r   <= 1'b0;
                            pio_writedata_r <= 32'(xfer_data_s);
                            state_r         <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (HAS_GAP) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= GAP_LOAD;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gap_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign req_ready      = grant_s;
    assign pio_chipselect = pio_cs_r;
    assign pio_address    = 2'b00;
    assign pio_write_n    = pio_write_n_r;
    assign pio_writedata  = pio_writedata_r;
    assign busy           = (state_r != ST_IDLE);
    assign err_sel        = err_sel_r;

endmodule

// File: tb/tb_score_pio_arbiter.sv
// Bench for score_pio_arbiter: directed scenarios on MIN_GAP=0/3/5 instances plus
// randomized traffic checked against a busy-countdown reference model.
module tb_score_pio_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req0_sel, req1_sel;
    logic [15:0] req0_data, req1_data;

    logic [1:0]  rdy  [3];
    logic [2:0]  cs   [3];
    logic [1:0]  addr [3];
    logic        wn   [3];
    logic [31:0] wd   [3];
    logic        bsy  [3];
    logic        err  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    score_pio_arbiter #(.DATA_W(16), .MIN_GAP(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req0_sel(req0_sel), .req0_data(req0_data), .req1_sel(req1_sel), .req1_data(req1_data),
        .pio_chipselect(cs[0]), .pio_address(addr[0]), .pio_write_n(wn[0]),
        .pio_writedata(wd[0]), .busy(bsy[0]), .err_sel(err[0]));

    score_pio_arbiter #(.DATA_W(16), .MIN_GAP(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req0_sel(req0_sel), .req0_data(req0_data), .req1_sel(req1_sel), .req1_data(req1_data),
        .pio_chipselect(cs[1]), .pio_address(addr[1]), .pio_write_n(wn[1]),
        .pio_writedata(wd[1]), .busy(bsy[1]), .err_sel(err[1]));

    score_pio_arbiter #(.DATA_W(16), .MIN_GAP(5)) dut5 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .req0_sel(req0_sel), .req0_data(req0_data), .req1_sel(req1_sel), .req1_data(req1_data),
        .pio_chipselect(cs[2]), .pio_address(addr[2]), .pio_write_n(wn[2]),
        .pio_writedata(wd[2]), .busy(bsy[2]), .err_sel(err[2]));

    task automatic apply_reset;
        reset = 1'b1; req_valid = 2'b00;
        req0_sel = 2'd0; req1_sel = 2'd0; req0_data = 16'd0; req1_data = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 2'b11;
        req0_sel = 2'd0; req1_sel = 2'd1; req0_data = 16'h1111; req1_data = 16'h2222;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (rdy[k] !== 2'b00) begin n_fail++; $display("FAIL reset_ready dut%0d got %b want 00", k, rdy[k]); end
            n_checks++; if (cs[k] !== 3'b000) begin n_fail++; $display("FAIL reset_cs dut%0d got %b want 000", k, cs[k]); end
            n_checks++; if (wn[k] !== 1'b1) begin n_fail++; $display("FAIL reset_write_n dut%0d got %b want 1", k, wn[k]); end
            n_checks++; if (wd[k] !== 32'd0) begin n_fail++; $display("FAIL reset_writedata dut%0d got %h want 0", k, wd[k]); end
            n_checks++; if (bsy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got %b want 0", k, bsy[k]); end
            n_checks++; if (err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err dut%0d got %b want 0", k, err[k]); end
            n_checks++; if (addr[k] !== 2'b00) begin n_fail++; $display("FAIL reset_address dut%0d got %b want 00", k, addr[k]); end
        end
        req_valid = 2'b00;
        reset = 1'b0;
    endtask

    task automatic test_single;
        apply_reset();
        req_valid = 2'b01; req0_sel = 2'd0; req0_data = 16'h0123;
        #1;
        n_checks++; if (rdy[0] !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b want 01", rdy[0]); end
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++; if (cs[0] !== 3'b001) begin n_fail++; $display("FAIL single_cs got %b want 001", cs[0]); end
        n_checks++; if (wn[0] !== 1'b0) begin n_fail++; $display("FAIL single_write_n got %b want 0", wn[0]); end
        n_checks++; if (wd[0] !== 32'h0000_0123) begin n_fail++; $display("FAIL single_writedata got %h want 00000123", wd[0]); end
        n_checks++; if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", bsy[0]); end
        @(negedge clk);
        n_checks++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", bsy[0]); end
        n_checks++; if (wn[0] !== 1'b1) begin n_fail++; $display("FAIL single_write_n_end got %b want 1", wn[0]); end
        n_checks++; if (cs[0] !== 3'b000) begin n_fail++; $display("FAIL single_cs_end got %b want 000", cs[0]); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_rdy;
        logic [2:0] exp_cs;
        apply_reset();
        req_valid = 2'b11; req0_sel = 2'd1; req0_data = 16'h0011; req1_sel = 2'd2; req1_data = 16'h0022;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rdy = (i % 2 == 0) ? (((i / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_cs  = (i % 2 == 1) ? (((i / 2) % 2 == 0) ? 3'b010 : 3'b100) : 3'b000;
            n_checks++; if (rdy[0] !== exp_rdy) begin n_fail++; $display("FAIL contention_ready cyc%0d got %b want %b", i, rdy[0], exp_rdy); end
            n_checks++; if (cs[0] !== exp_cs) begin n_fail++; $display("FAIL contention_cs cyc%0d got %b want %b", i, cs[0], exp_cs); end
            @(negedge clk);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_gap;
        logic [15:0] d;
        apply_reset();
        d = 16'($urandom);
        req_valid = 2'b01; req0_sel = 2'd2; req0_data = d;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++; if (wn[1] !== ((i % 5 == 1) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL gap_write_n cyc%0d got %b", i, wn[1]); end
            n_checks++; if (bsy[1] !== ((i % 5 != 0) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL gap_busy cyc%0d got %b", i, bsy[1]); end
            if (i % 5 == 1) begin
                n_checks++; if (wd[1] !== {16'd0, d}) begin n_fail++; $display("FAIL gap_writedata cyc%0d got %h want %h", i, wd[1], d); end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_illegal;
        apply_reset();
        req_valid = 2'b01; req0_sel = 2'd0; req0_data = 16'h000A; req1_sel = 2'd3; req1_data = 16'h00EE;
        #1;
        n_checks++; if (rdy[0] !== 2'b01) begin n_fail++; $display("FAIL illegal_pre_ready got %b want 01", rdy[0]); end
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        n_checks++; if (rdy[0] !== 2'b00) begin n_fail++; $display("FAIL illegal_write_ready got %b want 00", rdy[0]); end
        @(negedge clk);
        #1;
        n_checks++; if (rdy[0] !== 2'b10) begin n_fail++; $display("FAIL illegal_ready got %b want 10", rdy[0]); end
        @(negedge clk);
        req_valid = 2'b11; req1_sel = 2'd1;
        #1;
        n_checks++; if (err[0] !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", err[0]); end
        n_checks++; if (cs[0] !== 3'b000) begin n_fail++; $display("FAIL illegal_cs got %b want 000", cs[0]); end
        n_checks++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL illegal_busy got %b want 0", bsy[0]); end
        n_checks++; if (rdy[0] !== 2'b01) begin n_fail++; $display("FAIL illegal_rr_ready got %b want 01", rdy[0]); end
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL illegal_err_end got %b want 0", err[0]); end
        n_checks++; if (cs[0] !== 3'b001) begin n_fail++; $display("FAIL illegal_next_cs got %b want 001", cs[0]); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        req_valid = 2'b01; req0_sel = 2'd1; req0_data = 16'h0077;
        #1;
        n_checks++; if (rdy[2] !== 2'b01) begin n_fail++; $display("FAIL midrst_ready got %b want 01", rdy[2]); end
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++; if (wn[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_strobe got %b want 0", wn[2]); end
        @(negedge clk);
        n_checks++; if (bsy[2] !== 1'b1) begin n_fail++; $display("FAIL midrst_gap_busy got %b want 1", bsy[2]); end
        @(negedge clk);
        reset = 1'b1; req_valid = 2'b11; req1_sel = 2'd2; req1_data = 16'h0099;
        @(negedge clk);
        n_checks++; if (bsy[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bsy[2]); end
        n_checks++; if (wn[2] !== 1'b1) begin n_fail++; $display("FAIL midrst_write_n got %b want 1", wn[2]); end
        n_checks++; if (rdy[2] !== 2'b00) begin n_fail++; $display("FAIL midrst_ready_in_reset got %b want 00", rdy[2]); end
        reset = 1'b0;
        #1;
        n_checks++; if (rdy[2] !== 2'b01) begin n_fail++; $display("FAIL midrst_first_grant got %b want 01", rdy[2]); end
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++; if (cs[2] !== 3'b010) begin n_fail++; $display("FAIL midrst_cs got %b want 010", cs[2]); end
    endtask

    task automatic test_data_hold;
        apply_reset();
        req_valid = 2'b01; req0_sel = 2'd2; req0_data = 16'hBEEF;
        @(posedge clk);
        #1;
        req0_data = 16'h5555; req0_sel = 2'd0; req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (wd[0] !== 32'h0000_BEEF) begin n_fail++; $display("FAIL hold_writedata got %h want 0000beef", wd[0]); end
        n_checks++; if (cs[0] !== 3'b100) begin n_fail++; $display("FAIL hold_cs got %b want 100", cs[0]); end
    endtask

    task automatic test_random;
        int          gaps  [3] = '{0, 3, 5};
        int          block [3];
        bit          last  [3];
        logic [2:0]  m_cs  [3];
        logic [31:0] m_wd  [3];
        bit          m_err [3];
        logic [1:0]  exp_rdy;
        logic [1:0]  s;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            block[k] = 0; last[k] = 1'b1; m_cs[k] = 3'b000; m_wd[k] = 32'd0; m_err[k] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (cs[k] !== m_cs[k]) begin n_fail++; $display("FAIL rnd_cs dut%0d cyc%0d got %b want %b", k, c, cs[k], m_cs[k]); end
                n_checks++; if (wn[k] !== (m_cs[k] == 3'b000)) begin n_fail++; $display("FAIL rnd_write_n dut%0d cyc%0d got %b", k, c, wn[k]); end
                n_checks++; if (wd[k] !== m_wd[k]) begin n_fail++; $display("FAIL rnd_writedata dut%0d cyc%0d got %h want %h", k, c, wd[k], m_wd[k]); end
                n_checks++; if (bsy[k] !== (block[k] > 0)) begin n_fail++; $display("FAIL rnd_busy dut%0d cyc%0d got %b", k, c, bsy[k]); end
                n_checks++; if (err[k] !== m_err[k]) begin n_fail++; $display("FAIL rnd_err dut%0d cyc%0d got %b want %b", k, c, err[k], m_err[k]); end
            end
            reset     = ($urandom_range(0, 39) == 0);
            req_valid = 2'($urandom);
            req0_sel  = 2'($urandom);
            req1_sel  = 2'($urandom);
            req0_data = 16'($urandom);
            req1_data = 16'($urandom);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (reset || block[k] > 0) exp_rdy = 2'b00;
                else if (req_valid == 2'b11) exp_rdy = last[k] ? 2'b01 : 2'b10;
                else exp_rdy = req_valid;
                n_checks++; if (rdy[k] !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready dut%0d cyc%0d got %b want %b", k, c, rdy[k], exp_rdy); end
                if (reset) begin
                    block[k] = 0; last[k] = 1'b1; m_cs[k] = 3'b000; m_wd[k] = 32'd0; m_err[k] = 1'b0;
                end else begin
                    m_cs[k] = 3'b000; m_wd[k] = 32'd0; m_err[k] = 1'b0;
                    if (block[k] > 0) block[k]--;
                    if (exp_rdy != 2'b00) begin
                        last[k] = exp_rdy[1];
                        s = exp_rdy[1] ? req1_sel : req0_sel;
                        if (s == 2'd3) begin
                            m_err[k] = 1'b1;
                        end else begin
                            m_cs[k]  = 3'b001 << s;
                            m_wd[k]  = {16'd0, exp_rdy[1] ? req1_data : req0_data};
                            block[k] = 1 + gaps[k];
                        end
                    end
                end
            end
        end
        reset = 1'b0;
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_gap();
        test_illegal();
        test_reset_mid();
        test_data_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
